// File: rtl/impulse_pkg.sv
// ---------------------------------------------------------------------------
// impulse_pkg
// Shared definitions for the impulse capture and playback paths: line
// geometry, the reader state encoding and the slot-extraction helper that
// fixes the packed line format (earliest sample in the most significant slot).
// ---------------------------------------------------------------------------
package impulse_pkg;

  localparam int SAMPLE_WIDTH     = 16;
  localparam int SAMPLES_PER_LINE = 64;
  localparam int LINE_WIDTH       = 1024;
  localparam int LINE_ADDR_WIDTH  = 16;
  localparam int IDX_WIDTH        = 16;
  localparam int WORD_WIDTH       = 6;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FETCH  = 2'd1,
    STREAM = 2'd2
  } reader_state_t;

  // Slot k of a line lives in bits [1023-16k : 1008-16k].
  function automatic logic [SAMPLE_WIDTH-1:0] line_slot(
    input logic [LINE_WIDTH-1:0] line,
    input logic [WORD_WIDTH-1:0] word
  );
    return line[(LINE_WIDTH - 1) - (SAMPLE_WIDTH * int'(word)) -: SAMPLE_WIDTH];
  endfunction

endpackage

// File: rtl/impulse_line_buffer.sv
// ---------------------------------------------------------------------------
// impulse_line_buffer
// Holds the memory line(s) being played back and selects one 16-bit slot.
// Build option: IMPULSE_READER_PREFETCH_EN -> two lines (front/back); load
// writes the back line, swap promotes it to the front. Otherwise one line,
// load overwrites it and swap has no effect.
// Ports:
//   audio_clk, rst_in : clock, asynchronous active-high reset
//   load              : capture line_in
//   swap              : exchange front and back lines (dual build only)
//   line_in [1023:0]  : memory line
//   word    [5:0]     : slot index within the front line
//   slot    [15:0]    : selected sample (combinational)
// ---------------------------------------------------------------------------
module impulse_line_buffer
  import impulse_pkg::*;
(
  input  logic                    audio_clk,
  input  logic                    rst_in,
  input  logic                    load,
  input  logic                    swap,
  input  logic [LINE_WIDTH-1:0]   line_in,
  input  logic [WORD_WIDTH-1:0]   word,
  output logic [SAMPLE_WIDTH-1:0] slot
);

`ifdef IMPULSE_READER_PREFETCH_EN
  logic [LINE_WIDTH-1:0] line_r [2];
  logic                  front_r;

  // Back line is filled by load; swap flips which line is read. When both
  // occur together the freshly loaded line becomes the front line.
  always_ff @(posedge audio_clk or posedge rst_in) begin
    if (rst_in) begin
      line_r[0] <= {LINE_WIDTH{1'b0}};
      line_r[1] <= {LINE_WIDTH{1'b0}};
      front_r   <= 1'b0;
    end else begin
      if (load) begin
        line_r[~front_r] <= line_in;
      end
      if (swap) begin
        front_r <= ~front_r;
      end
    end
  end

  assign slot = line_slot(line_r[front_r], word);
`else
  logic [LINE_WIDTH-1:0] line_r;
  logic                  unused_swap_s;

  // Single line, overwritten on every load.
  always_ff @(posedge audio_clk or posedge rst_in) begin
    if (rst_in) begin
      line_r <= {LINE_WIDTH{1'b0}};
    end else if (load) begin
      line_r <= line_in;
    end
  end

  assign unused_swap_s = swap;
  assign slot          = line_slot(line_r, word);
`endif

endmodule

// File: rtl/impulse_reader.sv
// ---------------------------------------------------------------------------
// impulse_reader
// Streams a stored impulse response: fetches packed 1024-bit lines (64 signed
// 16-bit samples each) and hands out one sample per consumer request.
// Build option: IMPULSE_READER_PREFETCH_EN -> the next line is read into a
// second buffer while the current one streams, so line boundaries cost no
// FETCH pass. Default build: one buffer, FETCH at every line boundary.
// Parameters:
//   IMPULSE_LENGTH : samples per playback (last line may be partial)
//   READ_LATENCY   : cycles from read_enable to read_data valid (>= 1)
// Ports:
//   audio_clk, rst_in   : clock, asynchronous active-high reset
//   start_in            : pulse, start playback at sample 0 (ignored if busy)
//   sample_req          : pulse, consumer wants the next sample
//   read_data [1023:0]  : memory line, READ_LATENCY cycles after read_enable
//   read_line_addr [15:0], read_enable : memory read request
//   sample_out [15:0]   : current sample (signed), held between updates
//   sample_valid        : pulse when sample_out updates
//   impulse_done        : pulse alongside the final sample's sample_valid
//   busy                : accepted start until impulse_done
//   underrun            : sticky, request arrived while one was pending
// ---------------------------------------------------------------------------
module impulse_reader
  import impulse_pkg::*;
#(
  parameter int IMPULSE_LENGTH = 48000,
  parameter int READ_LATENCY   = 2
)
(
  input  logic                          audio_clk,
  input  logic                          rst_in,
  input  logic                          start_in,
  input  logic                          sample_req,
  input  logic [LINE_WIDTH-1:0]         read_data,
  output logic [LINE_ADDR_WIDTH-1:0]    read_line_addr,
  output logic                          read_enable,
  output logic signed [SAMPLE_WIDTH-1:0] sample_out,
  output logic                          sample_valid,
  output logic                          impulse_done,
  output logic                          busy,
  output logic                          underrun
);

  localparam int NUM_LINES = (IMPULSE_LENGTH + SAMPLES_PER_LINE - 1) / SAMPLES_PER_LINE;
  localparam logic [LINE_ADDR_WIDTH-1:0] NUM_LINES_C = LINE_ADDR_WIDTH'(NUM_LINES);
  localparam logic [IDX_WIDTH-1:0]       LAST_IDX_C  = IDX_WIDTH'(IMPULSE_LENGTH - 1);

  reader_state_t state_r, state_nxt_s;

  logic [IDX_WIDTH-1:0]           sample_idx_r;
  logic [READ_LATENCY-1:0]        rd_pipe_r;
  logic                           pending_r;
  logic [LINE_ADDR_WIDTH-1:0]     read_line_addr_r;
  logic                           read_enable_r;
  logic signed [SAMPLE_WIDTH-1:0] sample_out_r;
  logic                           sample_valid_r;
  logic                           impulse_done_r;
  logic                           busy_r;
  logic                           underrun_r;

  logic                           data_valid_s;
  logic [WORD_WIDTH-1:0]          word_s;
  logic [LINE_ADDR_WIDTH-1:0]     cur_line_s;
  logic [LINE_ADDR_WIDTH-1:0]     nxt_line_s;
  logic [SAMPLE_WIDTH-1:0]        slot_s;

  logic                           start_acc_s;
  logic                           serve_s;
  logic                           finish_s;
  logic                           issue_s;
  logic [LINE_ADDR_WIDTH-1:0]     issue_addr_s;
  logic                           load_s;
  logic                           swap_s;
  logic                           pend_set_s;
  logic                           pend_clr_s;
  logic                           unr_set_s;

`ifdef IMPULSE_READER_PREFETCH_EN
  logic                           alt_ready_r;
  logic                           alt_set_s;
  logic                           alt_clr_s;
  logic [LINE_ADDR_WIDTH-1:0]     nxt2_line_s;

  assign nxt2_line_s = cur_line_s + 16'd2;
`endif

  // During FETCH the index already points at the first sample of the line
  // being fetched, so cur_line_s is that line in both FETCH and STREAM.
  assign word_s       = sample_idx_r[WORD_WIDTH-1:0];
  assign cur_line_s   = {6'd0, sample_idx_r[IDX_WIDTH-1:WORD_WIDTH]};
  assign nxt_line_s   = cur_line_s + 16'd1;
  assign data_valid_s = rd_pipe_r[READ_LATENCY-1];

  impulse_line_buffer u_line_buffer (
    .audio_clk (audio_clk),
    .rst_in    (rst_in),
    .load      (load_s),
    .swap      (swap_s),
    .line_in   (read_data),
    .word      (word_s),
    .slot      (slot_s)
  );

  // FSM state register.
  always_ff @(posedge audio_clk or posedge rst_in) begin
    if (rst_in) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic and per-cycle control strobes.
  always_comb begin
    state_nxt_s  = state_r;
    start_acc_s  = 1'b0;
    serve_s      = 1'b0;
    finish_s     = 1'b0;
    issue_s      = 1'b0;
    issue_addr_s = {LINE_ADDR_WIDTH{1'b0}};
    load_s       = 1'b0;
    swap_s       = 1'b0;
    pend_set_s   = 1'b0;
    pend_clr_s   = 1'b0;
    unr_set_s    = 1'b0;
`ifdef IMPULSE_READER_PREFETCH_EN
    alt_set_s    = 1'b0;
    alt_clr_s    = 1'b0;
`endif
    case (state_r)
      IDLE: begin
        // A sample_req coinciding with start_in is intentionally not latched.
        if (start_in) begin
          start_acc_s  = 1'b1;
          issue_s      = 1'b1;
          issue_addr_s = {LINE_ADDR_WIDTH{1'b0}};
          state_nxt_s  = FETCH;
        end else begin
          state_nxt_s  = IDLE;
        end
      end

      FETCH: begin
        if (sample_req) begin
          if (pending_r) begin
            unr_set_s  = 1'b1;
          end else begin
            pend_set_s = 1'b1;
          end
        end else begin
          pend_set_s = 1'b0;
        end
        if (data_valid_s) begin
          load_s      = 1'b1;
          state_nxt_s = STREAM;
`ifdef IMPULSE_READER_PREFETCH_EN
          // Fresh line goes straight to the front; start fetching its successor.
          swap_s = 1'b1;
          if (nxt_line_s < NUM_LINES_C) begin
            issue_s      = 1'b1;
            issue_addr_s = nxt_line_s;
          end else begin
            issue_s      = 1'b0;
          end
`endif
        end else begin
          state_nxt_s = FETCH;
        end
      end

      STREAM: begin
        // A pending request is served first; a new one on top of it is dropped.
        serve_s    = sample_req | pending_r;
        pend_clr_s = pending_r;
        unr_set_s  = sample_req & pending_r;
`ifdef IMPULSE_READER_PREFETCH_EN
        load_s     = data_valid_s;
        alt_set_s  = data_valid_s;
`endif
        if (serve_s) begin
          if (sample_idx_r == LAST_IDX_C) begin
            finish_s    = 1'b1;
            state_nxt_s = IDLE;
          end else if (word_s == 6'd63) begin
`ifdef IMPULSE_READER_PREFETCH_EN
            if (alt_ready_r | data_valid_s) begin
              swap_s    = 1'b1;
              alt_clr_s = 1'b1;
              if (nxt2_line_s < NUM_LINES_C) begin
                issue_s      = 1'b1;
                issue_addr_s = nxt2_line_s;
              end else begin
                issue_s      = 1'b0;
              end
              state_nxt_s = STREAM;
            end else begin
              // Prefetch still in flight: wait for it without reissuing.
              state_nxt_s = FETCH;
            end
`else
            issue_s      = 1'b1;
            issue_addr_s = nxt_line_s;
            state_nxt_s  = FETCH;
`endif
          end else begin
            state_nxt_s = STREAM;
          end
        end else begin
          state_nxt_s = STREAM;
        end
      end

      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // Read-latency tag pipeline: the top bit marks the cycle read_data is valid.
  always_ff @(posedge audio_clk or posedge rst_in) begin
    if (rst_in) begin
      rd_pipe_r <= {READ_LATENCY{1'b0}};
    end else begin
      rd_pipe_r <= READ_LATENCY'({rd_pipe_r, read_enable_r});
    end
  end

  // Playback datapath: counters, flags and registered outputs.
  always_ff @(posedge audio_clk or posedge rst_in) begin
    if (rst_in) begin
      sample_idx_r     <= {IDX_WIDTH{1'b0}};
      pending_r        <= 1'b0;
      read_line_addr_r <= {LINE_ADDR_WIDTH{1'b0}};
      read_enable_r    <= 1'b0;
      sample_out_r     <= {SAMPLE_WIDTH{1'b0}};
      sample_valid_r   <= 1'b0;
      impulse_done_r   <= 1'b0;
      busy_r           <= 1'b0;
      underrun_r       <= 1'b0;
    end else begin
      read_enable_r  <= issue_s;
      sample_valid_r <= serve_s;
      impulse_done_r <= finish_s;
      if (issue_s) begin
        read_line_addr_r <= issue_addr_s;
      end
      if (serve_s) begin
        sample_out_r <= slot_s;
      end
      if (start_acc_s) begin
        sample_idx_r <= {IDX_WIDTH{1'b0}};
        busy_r       <= 1'b1;
        underrun_r   <= 1'b0;
        pending_r    <= 1'b0;
      end else begin
        if (finish_s) begin
          sample_idx_r <= {IDX_WIDTH{1'b0}};
          busy_r       <= 1'b0;
        end else if (serve_s) begin
          sample_idx_r <= sample_idx_r + 16'd1;
        end
        if (unr_set_s) begin
          underrun_r <= 1'b1;
        end
        if (pend_set_s) begin
          pending_r <= 1'b1;
        end else if (pend_clr_s) begin
          pending_r <= 1'b0;
        end
      end
    end
  end

`ifdef IMPULSE_READER_PREFETCH_EN
  // Marks the back buffer as holding the next line.
  always_ff @(posedge audio_clk or posedge rst_in) begin
    if (rst_in) begin
      alt_ready_r <= 1'b0;
    end else if (start_acc_s | alt_clr_s) begin
      alt_ready_r <= 1'b0;
    end else if (alt_set_s) begin
      alt_ready_r <= 1'b1;
    end
  end
`endif

  assign read_line_addr = read_line_addr_r;
  assign read_enable    = read_enable_r;
  assign sample_out     = sample_out_r;
  assign sample_valid   = sample_valid_r;
  assign impulse_done   = impulse_done_r;
  assign busy           = busy_r;
  assign underrun       = underrun_r;

endmodule

// File: tb/tb_impulse_reader.sv
// ---------------------------------------------------------------------------
// tb_impulse_reader
// Directed sequence with randomized request spacing against a memory whose
// line L slot k holds L*64+k, so the expected stream is simply 0,1,2,...
// ---------------------------------------------------------------------------
module tb_impulse_reader;

  localparam int LEN = 200;
  localparam int RL  = 2;

  logic                audio_clk = 1'b0;
  logic                rst_in;
  logic                start_in;
  logic                sample_req;
  logic [1023:0]       read_data;
  logic [15:0]         read_line_addr;
  logic                read_enable;
  logic signed [15:0]  sample_out;
  logic                sample_valid;
  logic                impulse_done;
  logic                busy;
  logic                underrun;

  int compared   = 0;
  int mismatched = 0;

  always #5 audio_clk = ~audio_clk;

  impulse_reader #(.IMPULSE_LENGTH(LEN), .READ_LATENCY(RL)) dut (
    .audio_clk      (audio_clk),
    .rst_in         (rst_in),
    .start_in       (start_in),
    .sample_req     (sample_req),
    .read_data      (read_data),
    .read_line_addr (read_line_addr),
    .read_enable    (read_enable),
    .sample_out     (sample_out),
    .sample_valid   (sample_valid),
    .impulse_done   (impulse_done),
    .busy           (busy),
    .underrun       (underrun)
  );

  // ---------------- memory model ----------------
  logic [15:0] mem_addr_q [RL];
  logic        mem_v_q    [RL];
  int          reads_q    [$];

  function automatic logic [1023:0] make_line(input logic [15:0] line);
    logic [1023:0] l;
    l = '0;
    for (int k = 0; k < 64; k++) l[1023 - 16*k -: 16] = 16'(int'(line) * 64 + k);
    return l;
  endfunction

  always @(posedge audio_clk) begin
    mem_v_q[0]    <= read_enable;
    mem_addr_q[0] <= read_line_addr;
    for (int i = 1; i < RL; i++) begin
      mem_v_q[i]    <= mem_v_q[i-1];
      mem_addr_q[i] <= mem_addr_q[i-1];
    end
    if (read_enable) reads_q.push_back(int'(read_line_addr));
  end

  assign read_data = (mem_v_q[RL-1] === 1'b1) ? make_line(mem_addr_q[RL-1])
                                               : {32{32'hDEAD_BEEF}};

  // ---------------- observation ----------------
  bit                 seen;
  bit                 last_done;
  logic signed [15:0] last_val;
  int                 valid_cnt = 0;
  int                 done_cnt  = 0;
  int                 run_len   = 0;
  int                 max_run   = 0;
  int                 got_q [$];

  task automatic tick();
    @(negedge audio_clk);
    seen = sample_valid;
    if (sample_valid) begin
      valid_cnt++;
      last_val  = sample_out;
      last_done = impulse_done;
      got_q.push_back(int'(sample_out));
      run_len++;
      if (run_len > max_run) max_run = run_len;
      if (impulse_done) done_cnt++;
    end else begin
      run_len = 0;
    end
  endtask

  task automatic check(input string tag, input longint obs, input longint exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One request per sample, spaced by a random gap after the previous sample.
  task automatic run_samples(input int first, input int last, input int start_busy_at,
                             input logic exp_unr);
    for (int i = first; i <= last; i++) begin
      int gap;
      int waited;
      int exp_lat;
      gap = (i == 64) ? 0 : int'($urandom_range(0, 5));
      if (i == start_busy_at + 1) begin
        start_in = 1'b1;
        tick();
        start_in = 1'b0;
      end
      repeat (gap) tick();
      sample_req = 1'b1;
      tick();
      sample_req = 1'b0;
      waited = 1;
      while (!seen && waited < 12) begin
        tick();
        waited++;
      end
      exp_lat = 1;
`ifndef IMPULSE_READER_PREFETCH_EN
      // Line start: read issued with the previous sample, RL cycles, register, serve.
      if (i % 64 == 0 && i > 0 && (RL + 2 - gap) > 1) exp_lat = RL + 2 - gap;
`endif
      check("sample_valid_seen", seen, 1);
      check("sample_value", last_val, i);
      if (i > first) check("req_latency", waited, exp_lat);
      check("done_flag", last_done, (i == LEN - 1));
      check("busy", busy, (i != LEN - 1));
      check("underrun", underrun, exp_unr);
    end
  endtask

  task automatic check_reads();
    check("read_count", reads_q.size(), (LEN + 63) / 64);
    for (int j = 0; j < reads_q.size(); j++) check("read_line", reads_q[j], j);
  endtask

  initial begin
    int base;
    rst_in     = 1'b1;
    start_in   = 1'b0;
    sample_req = 1'b0;
    repeat (3) tick();
    check("rst_sample_out", sample_out, 0);
    check("rst_valid", sample_valid, 0);
    check("rst_done", impulse_done, 0);
    check("rst_busy", busy, 0);
    check("rst_underrun", underrun, 0);
    check("rst_read_enable", read_enable, 0);
    check("rst_read_addr", read_line_addr, 0);
    rst_in = 1'b0;
    tick();

    // Requests in IDLE produce nothing.
    sample_req = 1'b1;
    tick();
    sample_req = 1'b0;
    repeat (5) tick();
    check("idle_req_ignored", valid_cnt, 0);
    check("idle_busy", busy, 0);

    // Run 1: start with a simultaneous request (request ignored), busy start at 50.
    reads_q.delete();
    start_in   = 1'b1;
    sample_req = 1'b1;
    tick();
    start_in   = 1'b0;
    sample_req = 1'b0;
    check("busy_after_start", busy, 1);
    repeat (6) tick();
    check("start_req_not_served", valid_cnt, 0);
    run_samples(0, LEN - 1, 50, 1'b0);
    repeat (4) tick();
    check("run1_valid_total", valid_cnt, LEN);
    check("run1_done_count", done_cnt, 1);
    check("run1_busy_low", busy, 0);
    check_reads();

    // Run 2: two requests during the first FETCH -> underrun, one served.
    base = valid_cnt;
    start_in = 1'b1;
    tick();
    start_in = 1'b0;
    sample_req = 1'b1;
    tick();
    sample_req = 1'b0;
    tick();
    sample_req = 1'b1;
    tick();
    sample_req = 1'b0;
    repeat (8) tick();
    check("unr_one_served", valid_cnt - base, 1);
    check("unr_first_value", last_val, 0);
    check("unr_flag", underrun, 1);
    run_samples(1, LEN - 1, -1, 1'b1);
    repeat (4) tick();
    check("unr_sticky", underrun, 1);
    check("run2_busy_low", busy, 0);

    // Run 3: start clears underrun; reset asynchronously at sample 100.
    start_in = 1'b1;
    tick();
    start_in = 1'b0;
    check("start_clears_unr", underrun, 0);
    check("run3_busy", busy, 1);
    run_samples(0, 100, -1, 1'b0);
    rst_in = 1'b1;
    #1;
    check("arst_sample_out", sample_out, 0);
    check("arst_valid", sample_valid, 0);
    check("arst_busy", busy, 0);
    check("arst_read_enable", read_enable, 0);
    check("arst_read_addr", read_line_addr, 0);
    check("arst_done", impulse_done, 0);
    repeat (2) tick();
    rst_in = 1'b0;
    base = valid_cnt;
    repeat (6) tick();
    check("arst_no_output", valid_cnt - base, 0);

    // Run 4: replay from sample 0 after reset.
    reads_q.delete();
    start_in = 1'b1;
    tick();
    start_in = 1'b0;
    run_samples(0, LEN - 1, -1, 1'b0);
    repeat (4) tick();
    check_reads();

`ifdef IMPULSE_READER_PREFETCH_EN
    // Run 5: request every cycle once the first line is in.
    reads_q.delete();
    start_in = 1'b1;
    tick();
    start_in = 1'b0;
    repeat (RL + 3) tick();
    got_q.delete();
    max_run = 0;
    sample_req = 1'b1;
    repeat (LEN) tick();
    sample_req = 1'b0;
    repeat (4) tick();
    check("pf_stream_count", got_q.size(), LEN);
    check("pf_consecutive", max_run, LEN);
    for (int j = 0; j < got_q.size(); j++) check("pf_value", got_q[j], j);
    check("pf_underrun", underrun, 0);
    check("pf_busy_low", busy, 0);
    check_reads();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
